imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. Accepts an instruction word plus an immediate-type select over a valid/ready handshake. Produces the XLEN-wide extended immediate one cycle later through a 2-entry buffer, so back-pressure from execute never drops or corrupts an immediate. Extends the base I/S/B/J/U set with CSR zimm, shift-amount and illegal-select detection.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64
INSTR_WIDTH, 32, instruction width; fixed at 32
TAG_W, 5, width of the sideband tag carried with each immediate (e.g. rd or ROB index)
ERR_CNT_W, 8, width of the saturating illegal-select counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush; discards all buffered entries
in_valid  in  1  input entry valid
in_ready  out  1  buffer can accept an entry this cycle
in_instr  in  INSTR_WIDTH  instruction word
in_imm_src  in  3  immediate type select
in_tag  in  TAG_W  sideband tag
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head entry
out_imm  out  XLEN  extended immediate
out_tag  out  TAG_W  tag of head entry
out_illegal  out  1  head entry had illegal select
err_cnt  out  ERR_CNT_W  count of accepted illegal selects, saturating

Behaviour:
- Select encoding, sign bit is instr[31] unless stated:
  - 000 I: instr[31:20]
  - 001 S: {instr[31:25], instr[11:7]}
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 = instr[31]
  - 101 Z: zero-extended instr[19:15]
  - 110 SHAMT: zero-extended instr[25:20] if XLEN=64, else instr[24:20]
  - 111 illegal: imm = 0 and illegal flag = 1
- Sign extension fills every bit from the field MSB+1 up to XLEN-1.
- Extension is computed combinationally at push. The buffer stores {imm, tag, illegal}.
- Buffer: 2-entry circular FIFO with 1-bit read/write pointers and a 2-bit count.
  - in_ready = (count != 2); it depends only on registered state, never on out_ready.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - out_valid = (count != 0). out_imm, out_tag and out_illegal always show the head entry.
- Latency: an entry pushed at edge N is visible at the outputs after edge N, in the following cycle. There is no same-cycle bypass.
- Order is strictly FIFO.
- While out_valid && !out_ready, the out_* signals hold stable.
- Simultaneous push and pop:
  - count 1: count stays 1 and the head advances.
  - count 2: no push is possible (in_ready=0); the pop gives count 1.
  - count 0: push only.
- err_cnt increments on each push with select 111 and saturates at 2^ERR_CNT_W-1. Flush does not clear it.
- flush (synchronous) sets count=0 and both pointers to 0, and ignores any push or pop in the same cycle. Next cycle: out_valid=0, in_ready=1.
- Reset (rst_n low, asynchronous, including mid-transfer):
  - count=0, pointers=0, storage=0, err_cnt=0.
  - Outputs: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=1 (combinational from count).
  - Pending entries are lost.
- Upper in_instr bits that are unused by a select are ignored. Unused encodings do not exist; all 8 are defined.

Test Plan:
- XLEN=32, I, instr=0xFFF00093, tag=3 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=3, out_illegal=0.
- XLEN=32, B, instr=0xFE000EE3 -> out_imm=0xFFFFFFFC. Z, instr=0x000F8000 -> out_imm=0x0000001F.
- XLEN=64, U, instr=0x800002B7 -> out_imm=0xFFFFFFFF80000000. SHAMT, instr=0x03F00000 -> out_imm=0x000000000000003F.
- out_ready=0, push tags 1,2,3 back-to-back -> tags 1 and 2 accepted, in_ready=0 after the 2nd push, out_tag holds 1. Raise out_ready with simultaneous push of 3 at count 1 -> outputs 1,2,3 in order, no loss or duplicate.
- Select 111 pushed 300 times -> each out_imm=0 with out_illegal=1; err_cnt saturates at 255. Flush leaves err_cnt at 255; reset gives 0.
- Count=2 with flush asserted alongside in_valid -> next cycle out_valid=0, in_ready=1, flushed entry absent. Repeat with asynchronous rst_n low mid-cycle -> outputs zero immediately.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: extends the selected immediate field at push time
// and buffers {imm, tag, illegal} in a 2-entry FIFO so execute back-pressure never loses data.
module imm_extend_pipe #(
    parameter int XLEN        = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int TAG_W       = 5,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [2:0]             in_imm_src,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_imm,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_illegal,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam int ENTRY_W = XLEN + TAG_W + 1;

    logic [XLEN-1:0]          imm_calc;
    logic                     illegal_calc;
    logic [1:0]               count_reg, count_next;
    logic                     wr_ptr_reg, rd_ptr_reg;
    logic [ERR_CNT_W-1:0]     err_cnt_reg;
    logic                     push, pop;
    logic [1:0][ENTRY_W-1:0]  entry_bus;
    logic [ENTRY_W-1:0]       head;
    logic                     unused_opcode_bits;

    // The opcode field never contributes to any immediate.
    assign unused_opcode_bits = ^in_instr[6:0];

    // Signed size casts perform the sign fill from the field MSB up to XLEN-1.
    always_comb begin
        imm_calc     = '0;
        illegal_calc = 1'b0;
        unique case (in_imm_src)
            3'b000: imm_calc = XLEN'($signed(in_instr[31:20]));
            3'b001: imm_calc = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            3'b010: imm_calc = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                              in_instr[11:8], 1'b0}));
            3'b011: imm_calc = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                              in_instr[30:21], 1'b0}));
            3'b100: imm_calc = XLEN'($signed({in_instr[31:12], 12'b0}));
            3'b101: imm_calc = XLEN'(in_instr[19:15]);
            3'b110: begin
                if (XLEN == 64) imm_calc = XLEN'(in_instr[25:20]);
                else            imm_calc = XLEN'(in_instr[24:20]);
            end
            default: illegal_calc = 1'b1;
        endcase
    end

    assign in_ready   = (count_reg != 2'd2);
    assign out_valid  = (count_reg != 2'd0);
    assign push       = in_valid && in_ready && !flush;
    assign pop        = out_valid && out_ready && !flush;
    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else if (flush) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Saturating count of illegal selects that were actually accepted; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_reg <= '0;
        else if (push && illegal_calc && (err_cnt_reg != {ERR_CNT_W{1'b1}}))
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg <= '0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    entry_reg <= {imm_calc, in_tag, illegal_calc};
            end
            assign entry_bus[gi] = entry_reg;
        end
    endgenerate

    assign head        = entry_bus[rd_ptr_reg];
    assign out_imm     = head[ENTRY_W-1 -: XLEN];
    assign out_tag     = head[TAG_W:1];
    assign out_illegal = head[0];
    assign err_cnt     = err_cnt_reg;

endmodule
